// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU control codes
// and multiply/divide unit encodings.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  localparam logic MDU_OP_MULTU = 1'b0;
  localparam logic MDU_OP_DIVU  = 1'b1;

endpackage

// File: rtl/mdu_sequencer_alu.sv
// Core 32-bit ALU, combinational, driven by
// the ALU control codes from mips_pkg.
module ALU
  import mips_pkg::*;
(
  input  logic [3:0]  ALUControl,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic [4:0]  shiftvalue,
  output logic [31:0] ALUResult,
  output logic        zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_AND:  ALUResult = Data1 & Data2;
      ALU_OR:   ALUResult = Data1 | Data2;
      ALU_ADD:  ALUResult = Data1 + Data2;
      ALU_SUB:  ALUResult = Data1 - Data2;
      ALU_SLT:  ALUResult = {31'b0,
                  $signed(Data1) < $signed(Data2)};
      ALU_SLTU: ALUResult = {31'b0, Data1 < Data2};
      ALU_SLL:  ALUResult = Data2 << shiftvalue;
      ALU_SRL:  ALUResult = Data2 >> shiftvalue;
      default:  ALUResult = '0;
    endcase
  end

  assign zero = (ALUResult == '0);

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULTU/DIVU unit: one bit per cycle,
// 32 steps, results into HI/LO.
module mdu_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t       state;
  logic             op_q;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo_w;
  logic [WIDTH-1:0] opnd;

  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] alu_out;
  logic             unused_zero;
  logic [WIDTH-1:0] rem;
  logic             ge;
  logic             carry;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] lo_nxt;

  ALU u_alu (
    .ALUControl (alu_ctl),
    .Data1      (d1),
    .Data2      (d2),
    .shiftvalue (5'd0),
    .ALUResult  (alu_out),
    .zero       (unused_zero)
  );

  // ov (acc msb) forces a subtract: the shifted
  // remainder then exceeds any 32-bit divisor.
  always_comb begin
    alu_ctl = ALU_ADD;
    d1      = acc;
    d2      = '0;
    rem     = {acc[WIDTH-2:0], lo_w[WIDTH-1]};
    ge      = 1'b0;
    carry   = 1'b0;
    acc_nxt = acc;
    lo_nxt  = lo_w;
    if (op_q == MDU_OP_DIVU) begin
      alu_ctl = ALU_SUB;
      d1      = rem;
      d2      = opnd;
      ge      = acc[WIDTH-1] | (rem >= opnd);
      acc_nxt = ge ? alu_out : rem;
      lo_nxt  = {lo_w[WIDTH-2:0], ge};
    end else begin
      alu_ctl = ALU_ADD;
      d1      = acc;
      d2      = lo_w[0] ? opnd : '0;
      carry   = (alu_out < acc);
      acc_nxt = {carry, alu_out[WIDTH-1:1]};
      lo_nxt  = {alu_out[0], lo_w[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MDU_IDLE;
      op_q  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      lo_w  <= '0;
      opnd  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          if (start) begin
            state <= MDU_RUN;
            busy  <= 1'b1;
            op_q  <= op;
            cnt   <= 5'd31;
            acc   <= '0;
            lo_w  <= op ? rs_val : rt_val;
            opnd  <= op ? rt_val : rs_val;
          end
        end
        MDU_RUN: begin
          acc  <= acc_nxt;
          lo_w <= lo_nxt;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state <= MDU_DONE;
            done  <= 1'b1;
            hi    <= acc_nxt;
            lo    <= lo_nxt;
          end
        end
        MDU_DONE: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle unsigned multiply/divide unit (MULTU/DIVU) for the MIPS core. It iterates one bit per cycle through a 32-step shift-add or restoring-divide loop. Each step's 32-bit add or subtract runs on its own instance of the team's ALU, which it drives through the ALU control codes. Results land in the HI/LO registers read by MFHI/MFLO. The block sits beside the main execute stage; the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported; it fixes the iteration count at 32.
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge
- `start`  in  1  request a new operation; sampled only in IDLE
- `op`  in  1  0 = MULTU, 1 = DIVU; captured with `start`
- `rs_val`  in  32  multiplicand or dividend; captured with `start`
- `rt_val`  in  32  multiplier or divisor; captured with `start`
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse; high only in DONE
- `hi`  out  32  MULTU: product[63:32]. DIVU: remainder.
- `lo`  out  32  MULTU: product[31:0]. DIVU: quotient.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `start` is high. Capture `op`, load `cnt` = 31, and initialise the working registers:
  - MULTU: `acc` = 0, `lo_w` = `rt_val`, `opnd` = `rs_val`.
  - DIVU: `acc` = 0, `lo_w` = `rs_val`, `opnd` = `rt_val`.
- RUN → RUN while `cnt` != 0; `cnt` decrements each cycle. RUN → DONE when `cnt` == 0, after the step for that cycle executes. DONE → IDLE unconditionally.
- `start` is ignored in RUN and DONE. No queueing.
- MULTU step:
  - ALU inputs: ALUControl = 4'b0010 (add), Data1 = `acc`, Data2 = `lo_w[0]` ? `opnd` : 0.
  - `c` = (alu_out < Data1), compared unsigned in this block.
  - {`acc`, `lo_w`} ← {`c`, alu_out, `lo_w`} >> 1, as a 65-bit right shift.
- DIVU step:
  - `r` = {`acc[30:0]`, `lo_w[31]`}; `ov` = `acc[31]`.
  - ALU inputs: ALUControl = 4'b0110 (sub), Data1 = `r`, Data2 = `opnd`.
  - `ge` = `ov` | (`r` >= `opnd`).
  - `acc` ← `ge` ? alu_out : `r`; `lo_w` ← {`lo_w[30:0]`, `ge`}.
- `hi`/`lo` output registers load from `acc`/`lo_w` on the final RUN cycle only. They then hold until the next final RUN cycle or reset; they do not change during a later RUN.
- Divide by zero needs no special case. It yields `lo` = 32'hFFFFFFFF and `hi` = `rs_val`, and this is the defined behaviour.
- ALU `shiftvalue` is tied to 0. The ALU's `zero` output is unused.
- Reset, from any state: state = IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, `cnt` = 0, working registers = 0. An operation in flight is abandoned and no `done` is produced.

## Timing
- `start` sampled high in IDLE at edge k → RUN during cycles k+1 … k+32 (32 cycles) → DONE in cycle k+33 → IDLE in cycle k+34.
- `busy` is high from k+1 through k+33 inclusive.
- `done` is high only in cycle k+33, and `hi`/`lo` are valid in that same cycle.
- Earliest next accept is edge k+34. Fixed latency of 33 cycles from accept to `done`, independent of `op` and operand values.
- ALU path is combinational within one cycle: registers → ALU → registers.
- `reset` asserted together with `start` means reset wins.

## Structure
- Shared package `mips_pkg` holds:
  - ALU control constants `ALU_AND`=4'b0000, `ALU_OR`=4'b0001, `ALU_ADD`=4'b0010, `ALU_SUB`=4'b0110, `ALU_SLT`=4'b0111, `ALU_SLTU`=4'b1000, `ALU_SLL`=4'b1001, `ALU_SRL`=4'b1010.
  - MDU state encoding `MDU_IDLE`/`MDU_RUN`/`MDU_DONE`.
  - `MDU_OP_MULTU`=0, `MDU_OP_DIVU`=1.
- One sub-module instance: `ALU`, the team's existing ALU, used unchanged. Carry and compare logic stays local to `mdu_sequencer`.

## Test plan
- MULTU rs=32'hFFFFFFFF, rt=32'hFFFFFFFF → `done` at k+33, `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- DIVU rs=100, rt=7 → `lo`=14, `hi`=2. DIVU rs=32'h80000000, rt=3 → `lo`=32'h2AAAAAAA, `hi`=2.
- DIVU rs=32'h12345678, rt=0 → `lo`=32'hFFFFFFFF, `hi`=32'h12345678, same 33-cycle latency.
- MULTU 6×7 started, then `start` with DIVU pulsed at cycles k+5 and k+33 → the extra starts are ignored, a single `done`, `hi`=0, `lo`=42.
- `reset` at k+10 during MULTU → next cycle `busy`=0, `hi`=`lo`=0, no `done`. A following DIVU 9/2 completes with `lo`=4, `hi`=1.
- Back-to-back: start at k+34 right after a completed op → accepted; `hi`/`lo` keep the old result until the new final RUN cycle.
